multicycle_ctrl: RTL and testbench

- Moore-style main control FSM for the multicycle CPU.
- Sequences fetch, decode, execute, memory and writeback.
- Drives the instruction register load strobe (IRWrite), PC write enables, memory strobes and datapath mux selects.
- Stalls on a memory-ready handshake, flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control bus between the multicycle main FSM and its datapath
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       i_opcode;
    logic             i_mem_ready;
    logic             o_IRWrite;
    logic             o_PCWrite;
    logic             o_PCWriteCond;
    logic             o_IorD;
    logic             o_MemRead;
    logic             o_MemWrite;
    logic             o_MemtoReg;
    logic             o_RegDst;
    logic             o_RegWrite;
    logic             o_ALUSrcA;
    logic [1:0]       o_ALUSrcB;
    logic [1:0]       o_ALUOp;
    logic [1:0]       o_PCSource;
    logic [3:0]       o_state;
    logic             o_illegal;
    logic [CNT_W-1:0] o_retired;

    // Controller side: consumes opcode/ready, produces strobes and selects
    modport master (
        input  i_opcode, i_mem_ready,
        output o_IRWrite, o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead, o_MemWrite,
               o_MemtoReg, o_RegDst, o_RegWrite, o_ALUSrcA, o_ALUSrcB, o_ALUOp,
               o_PCSource, o_state, o_illegal, o_retired
    );

    // Datapath side: the mirror image of the controller view
    modport slave (
        output i_opcode, i_mem_ready,
        input  o_IRWrite, o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead, o_MemWrite,
               o_MemtoReg, o_RegDst, o_RegWrite, o_ALUSrcA, o_ALUSrcB, o_ALUOp,
               o_PCSource, o_state, o_illegal, o_retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore main control FSM for the multicycle CPU
module multicycle_ctrl #(
    parameter int MEM_WAIT_EN = 1,
    parameter int CNT_W       = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    multicycle_ctrl_if.master       bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;

    state_t     w_next_state;
    logic       w_retire;
    logic       w_illegal;
    logic       w_ready;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_pcwritecond;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_iord;
    logic       w_memtoreg;
    logic       w_regdst;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_pcsource;

    // With waiting disabled the memory is assumed to complete every access in one cycle
    assign w_ready = (MEM_WAIT_EN != 0) ? bus.i_mem_ready : 1'b1;

    // Next-state selection, retire detection and illegal-opcode detection
    always_comb begin
        w_next_state = S_FETCH;
        w_retire     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH:  w_next_state = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.i_opcode)
                    OP_RTYPE:      w_next_state = S_EXEC;
                    OP_LW, OP_SW:  w_next_state = S_MEMADR;
                    OP_BEQ:        w_next_state = S_BRANCH;
                    OP_ADDI:       w_next_state = S_ADDIEX;
                    OP_J:          w_next_state = S_JUMP;
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            // Only lw/sw reach MEMADR and the IR still holds the opcode
            S_MEMADR: w_next_state = (bus.i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next_state = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_retire = 1'b1;
            S_MEMWR: begin
                w_next_state = w_ready ? S_FETCH : S_MEMWR;
                w_retire     = w_ready;
            end
            S_EXEC:   w_next_state = S_ALUWB;
            S_ALUWB:  w_retire = 1'b1;
            S_BRANCH: w_retire = 1'b1;
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_ADDIWB: w_retire = 1'b1;
            S_JUMP:   w_retire = 1'b1;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Moore decode of strobes and mux selects from the current state
    always_comb begin
        w_irwrite     = 1'b0;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_regwrite    = 1'b0;
        w_iord        = 1'b0;
        w_memtoreg    = 1'b0;
        w_regdst      = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = 2'b00;
        w_aluop       = 2'b00;
        w_pcsource    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                // IR and PC load only on the completing cycle so each fires once per fetch
                w_irwrite = w_ready;
                w_pcwrite = w_ready;
            end
            S_DECODE: w_alusrcb = 2'b11;
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            S_EXEC: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca     = 1'b1;
                w_aluop       = 2'b01;
                w_pcwritecond = 1'b1;
                w_pcsource    = 2'b01;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_ADDIWB: w_regwrite = 1'b1;
            S_JUMP: begin
                w_pcwrite  = 1'b1;
                w_pcsource = 2'b10;
            end
            default: ;
        endcase
    end

    // Strobes are masked by reset combinationally so they drop without waiting for a clock
    assign bus.o_IRWrite     = w_irwrite     & ~i_rst;
    assign bus.o_PCWrite     = w_pcwrite     & ~i_rst;
    assign bus.o_PCWriteCond = w_pcwritecond & ~i_rst;
    assign bus.o_MemRead     = w_memread     & ~i_rst;
    assign bus.o_MemWrite    = w_memwrite    & ~i_rst;
    assign bus.o_RegWrite    = w_regwrite    & ~i_rst;
    assign bus.o_illegal     = w_illegal     & ~i_rst;
    assign bus.o_IorD        = w_iord;
    assign bus.o_MemtoReg    = w_memtoreg;
    assign bus.o_RegDst      = w_regdst;
    assign bus.o_ALUSrcA     = w_alusrca;
    assign bus.o_ALUSrcB     = w_alusrcb;
    assign bus.o_ALUOp       = w_aluop;
    assign bus.o_PCSource    = w_pcsource;
    assign bus.o_state       = r_state;
    assign bus.o_retired     = r_retired;

    // State register and retired-instruction counter (wraps naturally at CNT_W bits)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for the multicycle control FSM
module tb_multicycle_ctrl;
    localparam int CW = 2;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct packed {
        logic [5:0] op;
        logic [3:0] st;
        logic       rdy;
        logic       ret;
    } ent_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   model_ret;
    ent_t sb[$];
    logic [16:0] obs_ctrl;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();

    multicycle_ctrl #(.MEM_WAIT_EN(1), .CNT_W(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign obs_ctrl = {bus.o_IRWrite, bus.o_PCWrite, bus.o_PCWriteCond, bus.o_IorD,
                       bus.o_MemRead, bus.o_MemWrite, bus.o_MemtoReg, bus.o_RegDst,
                       bus.o_RegWrite, bus.o_ALUSrcA, bus.o_ALUSrcB, bus.o_ALUOp,
                       bus.o_PCSource, bus.o_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                             input logic [5:0] op, input logic r);
        logic irw, pcw, pwc, iord, mr, mw, m2r, rd, rw, sa, ill;
        logic [1:0] srcb, aop, ps;
        irw = 0; pcw = 0; pwc = 0; iord = 0; mr = 0; mw = 0; m2r = 0; rd = 0;
        rw = 0; sa = 0; ill = 0; srcb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin irw = rdy; pcw = rdy; mr = 1; srcb = 2'b01; end
            4'd1:  begin srcb = 2'b11; ill = !(op inside {RT, LW, SW, BEQ, ADDI, JMP}); end
            4'd2:  begin sa = 1; srcb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin sa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            4'd9:  begin sa = 1; srcb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        if (r) begin
            irw = 0; pcw = 0; pwc = 0; mr = 0; mw = 0; rw = 0; ill = 0;
        end
        return {irw, pcw, pwc, iord, mr, mw, m2r, rd, rw, sa, srcb, aop, ps, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [3:0] st, input logic rdy,
                        input logic ret);
        ent_t e;
        e.op = op; e.st = st; e.rdy = rdy; e.ret = ret;
        sb.push_back(e);
    endtask

    // Expected per-cycle trace of one instruction: fw fetch stall cycles, mw memory wait cycles
    task automatic issue(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(op, 4'd0, 1'b0, 1'b0);
        push(op, 4'd0, 1'b1, 1'b0);
        push(op, 4'd1, 1'b1, 1'b0);
        case (op)
            LW: begin
                push(op, 4'd2, 1'b1, 1'b0);
                for (int i = 0; i < mw; i++) push(op, 4'd3, 1'b0, 1'b0);
                push(op, 4'd3, 1'b1, 1'b0);
                push(op, 4'd4, 1'b1, 1'b1);
            end
            SW: begin
                push(op, 4'd2, 1'b1, 1'b0);
                for (int i = 0; i < mw; i++) push(op, 4'd5, 1'b0, 1'b0);
                push(op, 4'd5, 1'b1, 1'b1);
            end
            RT: begin
                push(op, 4'd6, 1'b1, 1'b0);
                push(op, 4'd7, 1'b1, 1'b1);
            end
            ADDI: begin
                push(op, 4'd9, 1'b1, 1'b0);
                push(op, 4'd10, 1'b1, 1'b1);
            end
            BEQ: push(op, 4'd8, 1'b1, 1'b1);
            JMP: push(op, 4'd11, 1'b1, 1'b1);
            default: ;
        endcase
    endtask

    // Pops one expectation per cycle; called at a falling edge, returns at the next one
    task automatic drain();
        ent_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.i_mem_ready = e.rdy;
            bus.i_opcode    = e.op;
            #1;
            chk($sformatf("state op=%0h", e.op), {28'd0, bus.o_state}, {28'd0, e.st});
            chk($sformatf("ctrl st=%0d", e.st), {15'd0, obs_ctrl},
                {15'd0, exp_ctrl(e.st, e.rdy, e.op, 1'b0)});
            chk("retired", {30'd0, bus.o_retired}, model_ret % 4);
            @(posedge clk);
            if (e.ret) model_ret++;
            @(negedge clk);
        end
    endtask

    logic [5:0] ops [7];

    initial begin
        total = 0; bad = 0; model_ret = 0;
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = ADDI;
        ops[4] = BEQ; ops[5] = JMP; ops[6] = BAD;
        rst = 1'b1;
        bus.i_mem_ready = 1'b1;
        bus.i_opcode    = LW;
        repeat (3) @(negedge clk);
        #1;
        chk("reset state", {28'd0, bus.o_state}, 32'd0);
        chk("reset ctrl", {15'd0, obs_ctrl}, {15'd0, exp_ctrl(4'd0, 1'b1, LW, 1'b1)});
        chk("reset retired", {30'd0, bus.o_retired}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(LW, 0, 0);
        issue(SW, 0, 3);
        issue(LW, 2, 0);
        issue(RT, 0, 0);
        issue(ADDI, 0, 0);
        issue(BEQ, 0, 0);
        issue(JMP, 0, 0);
        issue(BAD, 0, 0);
        for (int k = 0; k < 8; k++) begin
            issue(ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3));
        end
        drain();
        #1;
        chk("idle state", {28'd0, bus.o_state}, 32'd0);
        chk("idle retired", {30'd0, bus.o_retired}, model_ret % 4);

        // Reach MEMRD of a lw, then hit reset between clock edges
        push(LW, 4'd0, 1'b1, 1'b0);
        push(LW, 4'd1, 1'b1, 1'b0);
        push(LW, 4'd2, 1'b1, 1'b0);
        drain();
        bus.i_mem_ready = 1'b0;
        #1;
        chk("memrd state", {28'd0, bus.o_state}, 32'd3);
        chk("memrd ctrl", {15'd0, obs_ctrl}, {15'd0, exp_ctrl(4'd3, 1'b0, LW, 1'b0)});
        #1;
        rst = 1'b1;
        #1;
        chk("async rst state", {28'd0, bus.o_state}, 32'd0);
        chk("async rst ctrl", {15'd0, obs_ctrl}, {15'd0, exp_ctrl(4'd0, 1'b0, LW, 1'b1)});
        chk("async rst retired", {30'd0, bus.o_retired}, 32'd0);
        model_ret = 0;
        @(negedge clk);
        rst = 1'b0;

        // Four completions from zero on a 2-bit counter: 0,1,2,3 then wraps to 0
        issue(JMP, 0, 0);
        issue(BEQ, 0, 0);
        issue(RT, 0, 0);
        issue(SW, 1, 1);
        drain();
        #1;
        chk("wrap retired", {30'd0, bus.o_retired}, 32'd0);
        chk("wrap state", {28'd0, bus.o_state}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
